// File: rtl/neopixel_driver.sv
// WS2812-style serial driver: a small pixel memory is streamed MSB-first as
// fixed-period pulse-width bits, followed by a low latch gap, whenever it has been written.
module neopixel_driver #(
  parameter int C_PIXELS = 12,
  parameter int C_T0H    = 50,
  parameter int C_T1H    = 100,
  parameter int C_TBIT   = 156,
  parameter int C_TRESET = 10000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        neopixel_out
);

  localparam int PIX_W  = (C_PIXELS > 1) ? $clog2(C_PIXELS) : 1;
  localparam int TBIT_W = (C_TBIT > 1) ? $clog2(C_TBIT) : 1;
  localparam int RST_W  = (C_TRESET > 1) ? $clog2(C_TRESET) : 1;

  localparam logic [31:0]       PIXELS_U   = 32'(C_PIXELS);
  localparam logic [31:0]       T0H_U      = 32'(C_T0H);
  localparam logic [31:0]       T1H_U      = 32'(C_T1H);
  localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(C_PIXELS - 1);
  localparam logic [TBIT_W-1:0] LAST_PHASE = TBIT_W'(C_TBIT - 1);
  localparam logic [RST_W-1:0]  LAST_GAP   = RST_W'(C_TRESET - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_LATCH
  } state_t;

  state_t              state_reg;
  logic [23:0]         pixel_mem [C_PIXELS];
  logic [23:0]         shift_reg;
  logic [TBIT_W-1:0]   phase_reg;
  logic [4:0]          bit_reg;
  logic [PIX_W-1:0]    pix_reg;
  logic [RST_W-1:0]    gap_reg;
  logic                dirty_reg;
  logic                ready_reg;
  logic                line_reg;
  logic [31:0]         read_data_reg;

  logic                addr_ok;
  logic                write_ok;
  logic [PIX_W-1:0]    addr_idx;
  logic [PIX_W-1:0]    next_pix;
  logic [23:0]         first_word;
  logic [23:0]         next_word;
  logic [TBIT_W-1:0]   phase_next;
  logic                unused_hi;

  assign addr_ok    = address < PIXELS_U;
  assign write_ok   = write_en && addr_ok;
  assign addr_idx   = address[PIX_W-1:0];
  assign next_pix   = pix_reg + PIX_W'(1);
  assign first_word = pixel_mem[0];
  assign next_word  = pixel_mem[next_pix];
  assign phase_next = phase_reg + TBIT_W'(1);
  assign unused_hi  = ^write_data[31:24];

  // Line level for a given bit value at a given phase within its bit period.
  function automatic logic high_at(input logic bit_val, input logic [TBIT_W-1:0] phase);
    logic [31:0] ph;
    ph = 32'(phase);
    return bit_val ? (ph < T1H_U) : (ph < T0H_U);
  endfunction

  // Pixel memory with registered readback; a same-edge load sees the old word.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < C_PIXELS; i++) begin
        pixel_mem[i] <= '0;
      end
      read_data_reg <= '0;
    end else begin
      if (write_ok) begin
        pixel_mem[addr_idx] <= write_data[23:0];
      end
      read_data_reg <= addr_ok ? {8'h00, pixel_mem[addr_idx]} : 32'h0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      phase_reg <= '0;
      bit_reg   <= '0;
      pix_reg   <= '0;
      gap_reg   <= '0;
      dirty_reg <= 1'b0;
      ready_reg <= 1'b0;
      line_reg  <= 1'b0;
    end else begin
      // A write landing on the same edge that starts a frame keeps dirty set.
      dirty_reg <= write_ok || (dirty_reg && (state_reg != ST_IDLE));

      case (state_reg)
        ST_IDLE: begin
          line_reg <= 1'b0;
          if (dirty_reg) begin
            state_reg <= ST_LOAD;
            ready_reg <= 1'b0;
          end else begin
            ready_reg <= 1'b1;
          end
        end

        ST_LOAD: begin
          shift_reg <= first_word;
          phase_reg <= '0;
          bit_reg   <= '0;
          pix_reg   <= '0;
          line_reg  <= high_at(first_word[23], '0);
          ready_reg <= 1'b0;
          state_reg <= ST_SEND;
        end

        ST_SEND: begin
          ready_reg <= 1'b0;
          if (phase_reg != LAST_PHASE) begin
            phase_reg <= phase_next;
            line_reg  <= high_at(shift_reg[23], phase_next);
          end else begin
            phase_reg <= '0;
            if (bit_reg != 5'd23) begin
              bit_reg   <= bit_reg + 5'd1;
              shift_reg <= {shift_reg[22:0], 1'b0};
              line_reg  <= high_at(shift_reg[22], '0);
            end else if (pix_reg != LAST_PIX) begin
              // Next word is fetched here so pixels run back-to-back.
              bit_reg   <= '0;
              pix_reg   <= next_pix;
              shift_reg <= next_word;
              line_reg  <= high_at(next_word[23], '0);
            end else begin
              bit_reg   <= '0;
              gap_reg   <= '0;
              line_reg  <= 1'b0;
              state_reg <= ST_LATCH;
            end
          end
        end

        ST_LATCH: begin
          line_reg <= 1'b0;
          if (gap_reg != LAST_GAP) begin
            gap_reg   <= gap_reg + RST_W'(1);
            ready_reg <= 1'b0;
          end else begin
            gap_reg   <= '0;
            ready_reg <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          line_reg  <= 1'b0;
          ready_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign read_data    = read_data_reg;
  assign ready        = ready_reg;
  assign neopixel_out = line_reg;

endmodule

// File: tb/tb_neopixel_driver.sv
// Directed bench for neopixel_driver with a frame-offset behavioural model
// compared against the outputs on every cycle.
module tb_neopixel_driver;

  localparam int P         = 2;
  localparam int T0H       = 50;
  localparam int T1H       = 100;
  localparam int TBIT      = 156;
  localparam int TRESET    = 10000;
  localparam int SEND_LEN  = 24 * P * TBIT;
  localparam int FRAME_LEN = 1 + SEND_LEN + TRESET;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        neopixel_out;

  always #5 clock = ~clock;

  neopixel_driver #(
    .C_PIXELS(P),
    .C_T0H(T0H),
    .C_T1H(T1H),
    .C_TBIT(TBIT),
    .C_TRESET(TRESET)
  ) dut (
    .clock(clock),
    .reset(reset),
    .write_en(write_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .neopixel_out(neopixel_out)
  );

  int total = 0;
  int bad   = 0;

  // Model state: memory, dirty flag, frame offset (-1 when idle), per-frame snapshots.
  logic [23:0] m_mem  [P];
  logic [23:0] m_snap [P];
  logic        m_dirty = 1'b0;
  int          m_pos   = -1;
  logic        e_out   = 1'b0;
  logic        e_ready = 1'b0;
  logic [31:0] e_rd    = 32'h0;

  // Frame measurements taken from the DUT line.
  int          f_ofs;
  logic [47:0] f_pat;
  int          f_hi0, f_lo0, f_hi1, f_lat_hi, f_lat_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Predict outputs after the coming rising edge from the inputs now applied.
  task automatic model_step();
    int nxt, k, b, ph, pix;
    logic clr, wr, bv;
    if (reset) begin
      for (int i = 0; i < P; i++) m_mem[i] = 24'h0;
      m_dirty = 1'b0;
      m_pos   = -1;
      e_out   = 1'b0;
      e_ready = 1'b0;
      e_rd    = 32'h0;
      return;
    end
    if (address < 32'(P)) e_rd = {8'h00, m_mem[int'(address)]};
    else                  e_rd = 32'h0;
    if (m_pos < 0) begin
      nxt = m_dirty ? 0 : -1;
      clr = m_dirty;
    end else begin
      nxt = m_pos + 1;
      if (nxt == FRAME_LEN) nxt = -1;
      clr = 1'b0;
    end
    if (m_pos >= 0 && (m_pos % (24 * TBIT)) == 0 && (m_pos / (24 * TBIT)) < P)
      m_snap[m_pos / (24 * TBIT)] = m_mem[m_pos / (24 * TBIT)];
    wr = write_en && (address < 32'(P));
    if (wr) m_mem[int'(address)] = write_data[23:0];
    m_dirty = wr || (m_dirty && !clr);
    e_ready = (nxt < 0);
    e_out   = 1'b0;
    if (nxt >= 1 && nxt <= SEND_LEN) begin
      k   = nxt - 1;
      b   = k / TBIT;
      ph  = k % TBIT;
      pix = b / 24;
      bv  = m_snap[pix][23 - (b % 24)];
      e_out = (ph < (bv ? T1H : T0H));
    end
    m_pos = nxt;
  endtask

  task automatic step();
    model_step();
    @(negedge clock);
    check("line", 64'(neopixel_out), 64'(e_out));
    check("ready", 64'(ready), 64'(e_ready));
    check("read_data", 64'(read_data), 64'(e_rd));
  endtask

  task automatic frame_begin();
    f_ofs = 0; f_pat = '0;
    f_hi0 = 0; f_lo0 = 0; f_hi1 = 0; f_lat_hi = 0; f_lat_lo = 0;
  endtask

  // Record the current sample at frame offset f_ofs, then advance one cycle.
  task automatic fstep();
    int k, j, ph;
    if (f_ofs >= 1 && f_ofs <= SEND_LEN) begin
      k = f_ofs - 1; j = k / TBIT; ph = k % TBIT;
      if (ph == 75) f_pat[47 - j] = neopixel_out;
      if (j == 0) begin
        if (neopixel_out) f_hi0++; else f_lo0++;
      end
      if (j == 1 && neopixel_out) f_hi1++;
    end else if (f_ofs > SEND_LEN) begin
      if (neopixel_out) f_lat_hi++; else f_lat_lo++;
    end
    f_ofs++;
    step();
  endtask

  task automatic watch(input int limit);
    while (ready == 1'b0 && f_ofs < limit) fstep();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    write_en = 1'b1; address = a; write_data = d;
    $display("write addr=%0d data=%08h", a, d);
  endtask

  initial begin
    int n_busy, n_high;
    reset = 1'b1; write_en = 1'b0; address = 32'h0; write_data = 32'h0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) step();
    check("rst_line", 64'(neopixel_out), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_read_data", 64'(read_data), 64'd0);
    reset = 1'b0;
    step();
    check("ready_after_reset", 64'(ready), 64'd1);
    for (int i = 0; i < 5; i++) step();

    // Out-of-range write: no frame, reads return zero
    do_write(32'd5, 32'h00123456);
    step();
    write_en = 1'b0; address = 32'd5;
    step();
    check("read_addr5", 64'(read_data), 64'd0);
    address = 32'd0;
    step();
    check("read_addr0", 64'(read_data), 64'd0);
    n_busy = 0; n_high = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!ready) n_busy++;
      if (neopixel_out) n_high++;
    end
    check("oor_no_frame_busy", 64'(n_busy), 64'd0);
    check("oor_no_frame_line", 64'(n_high), 64'd0);

    // Frame A: two back-to-back writes from idle
    do_write(32'd0, 32'h00A50F01);
    step();
    check("ready_before_load", 64'(ready), 64'd1);
    do_write(32'd1, 32'h00000000);
    step();
    write_en = 1'b0; address = 32'd0;
    check("ready_in_load", 64'(ready), 64'd0);
    frame_begin();
    watch(FRAME_LEN + 20);
    $display("frame A length=%0d pattern=%012h", f_ofs, f_pat);
    check("frameA_len", 64'(f_ofs), 64'(17489));
    check("frameA_pattern", 64'(f_pat), 64'h0000_A50F_0100_0000);
    check("frameA_bit0_high", 64'(f_hi0), 64'd100);
    check("frameA_bit0_low", 64'(f_lo0), 64'd56);
    check("frameA_bit1_high", 64'(f_hi1), 64'd50);
    check("frameA_latch_low", 64'(f_lat_lo), 64'd10000);
    check("frameA_latch_high", 64'(f_lat_hi), 64'd0);
    check("frameA_ready_back", 64'(ready), 64'd1);

    // The second write landed as dirty was cleared, so frame B follows at once
    step();
    check("frameB_starts", 64'(ready), 64'd0);
    frame_begin();
    watch(200);
    do_write(32'd1, 32'h0000ABCD);
    fstep();
    write_en = 1'b0; address = 32'd1;
    fstep();
    check("readback_abcd", 64'(read_data), 64'h0000ABCD);
    do_write(32'd1, 32'h00FFFFFF);
    fstep();
    write_en = 1'b0;
    fstep();
    check("readback_ffffff", 64'(read_data), 64'h00FFFFFF);
    watch(FRAME_LEN + 20);
    $display("frame B length=%0d pattern=%012h", f_ofs, f_pat);
    check("frameB_len", 64'(f_ofs), 64'(17489));
    check("frameB_pattern", 64'(f_pat), 64'h0000_A50F_01FF_FFFF);
    check("frameB_latch_low", 64'(f_lat_lo), 64'd10000);

    // Frame C repeats; reset it during bit 10 of pixel 0
    step();
    check("frameC_starts", 64'(ready), 64'd0);
    frame_begin();
    watch(1 + 10 * TBIT + 5);
    check("frameC_reached", 64'(f_ofs), 64'(1 + 10 * TBIT + 5));
    check("line_before_reset", 64'(neopixel_out), 64'd1);
    reset = 1'b1;
    step();
    $display("reset asserted mid-frame");
    check("line_after_reset", 64'(neopixel_out), 64'd0);
    check("ready_after_midreset", 64'(ready), 64'd0);
    step();
    step();
    reset = 1'b0; address = 32'd0;
    step();
    check("ready_after_release", 64'(ready), 64'd1);
    step();
    check("read_addr0_cleared", 64'(read_data), 64'd0);
    n_busy = 0; n_high = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!ready) n_busy++;
      if (neopixel_out) n_high++;
    end
    check("no_frame_after_reset_busy", 64'(n_busy), 64'd0);
    check("no_frame_after_reset_line", 64'(n_high), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neopixel_driver.md
NEOPIXEL_DRIVER -- requirements
Module: neopixel_driver

Interface
REQ-001 Parameter C_PIXELS, default 12: number of pixels in the chain and depth of the pixel memory.
REQ-002 Parameter C_T0H, default 50: clocks high for a 0 bit.
REQ-003 Parameter C_T1H, default 100: clocks high for a 1 bit.
REQ-004 Parameter C_TBIT, default 156: clocks per bit period.
REQ-005 Parameter C_TRESET, default 10000: clocks low for the latch gap after a frame.
REQ-006 clock  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 write_en  in  1  pixel write strobe, one cycle per write.
REQ-009 address  in  32  pixel index for write and read.
REQ-010 write_data  in  32  bits 23:0 = 24-bit pixel word; bits 31:24 ignored.
REQ-011 read_data  out  32  registered readback of pixel[address], zero-extended.
REQ-012 ready  out  1  high when the driver is idle and a write starts a new frame without delay.
REQ-013 neopixel_out  out  1  serial line to the first pixel.

Function
REQ-014 Pixel memory: C_PIXELS x 24-bit words.
REQ-015 Write accepted on any cycle with write_en=1 and address<C_PIXELS, regardless of ready or state; out-of-range writes ignored with no other effect.
REQ-016 An accepted write sets the dirty flag.
REQ-017 read_data = {8'h00, pixel[address]} one cycle after address is presented; 0 when address>=C_PIXELS.
REQ-018 A read in the cycle after a write to the same address returns the new value.
REQ-019 States: IDLE, LOAD, SEND, LATCH.
REQ-020 IDLE: neopixel_out=0, ready=1; dirty=1 -> LOAD next cycle, clearing dirty.
REQ-021 Dirty set and clear in the same cycle: set wins, so one further frame follows.
REQ-022 LOAD, one cycle: latch pixel[0] into the 24-bit shift register; then SEND.
REQ-023 SEND: pixels 0..C_PIXELS-1 in order, each MSB (bit 23) first.
REQ-024 Each bit period is exactly C_TBIT cycles: high C_T1H cycles for a 1, C_T0H for a 0, low for the remainder.
REQ-025 Bit periods and pixel boundaries are back-to-back; the next pixel word is read at the end of the current pixel's last bit, with no gap cycle.
REQ-026 A write to a pixel not yet loaded in the current frame appears in that frame; a write to a loaded pixel waits for the next frame.
REQ-027 After the last bit of pixel C_PIXELS-1 -> LATCH: neopixel_out=0 for exactly C_TRESET cycles, then IDLE.
REQ-028 ready=0 in LOAD, SEND and LATCH.
REQ-029 First rising edge of neopixel_out is 2 cycles after the IDLE cycle that sees dirty=1.
REQ-030 Total frame from LOAD entry to IDLE re-entry: 1 + 24*C_PIXELS*C_TBIT + C_TRESET cycles.
REQ-031 Bit and pixel counters sized to C_TBIT, 24 and C_PIXELS; no wrap beyond terminal counts.
REQ-032 Required: C_T0H < C_T1H < C_TBIT and C_PIXELS >= 1.

Reset
REQ-033 While reset=1: state=IDLE, neopixel_out=0, ready=0, read_data=0, dirty=0, all counters 0, all pixel words 0; writes ignored.
REQ-034 First cycle after reset deasserts: ready=1.
REQ-035 Reset mid-frame: neopixel_out=0 at the next edge, and no partial frame resumes.

Verification (C_PIXELS=2, other parameters default)
REQ-036 Reset for 3 cycles, then release -> neopixel_out=0, read_data=0, ready=0 during reset; ready=1 the first cycle after; line stays low.
REQ-037 Write addr0=0xA50F01, addr1=0x000000 back-to-back from IDLE -> first bit high 100 cycles, low 56; bit 1 high 50 cycles; full 48-bit pattern matches; then 10000 low cycles; ready returns 1 after 1+48*156+10000 cycles.
REQ-038 Write addr5=0x123456, then read addr5 and addr0 -> no frame starts, ready stays 1, read_data=0 for both.
REQ-039 Write addr1=0xFFFFFF during pixel 0 of a frame -> pixel 1 sent as 24 ones in that frame; a second identical frame follows the latch.
REQ-040 Assert reset at bit 10 of pixel 0 -> neopixel_out=0 next cycle; after release, read addr0 = 0 and no frame starts.
REQ-041 Write addr1=0x00ABCD, then present address=1 the next cycle -> read_data=0x0000ABCD one cycle later.
